// File: rtl/gshare_bht_pkg.sv
// ---------------------------------------------------------------------------
// gshare_bht_pkg
// Shared definitions for the gshare branch history table and the predictor
// blocks that will sit next to it in the frontend.
//   INSTR_PER_FETCH   - default number of predictions produced per fetch
//   GSHARE_HIST_BITS  - default global history length
//   GSHARE_CTR_BITS   - default saturating counter width
//   GSHARE_VLEN       - PC width used by the bundled update record
//   gshare_state_e    - states of the table clear sweep
//   gshare_update_t   - resolved-branch update record, for later bundling
// ---------------------------------------------------------------------------
package gshare_bht_pkg;

   localparam int unsigned INSTR_PER_FETCH  = 2;
   localparam int unsigned GSHARE_HIST_BITS = 8;
   localparam int unsigned GSHARE_CTR_BITS  = 2;
   localparam int unsigned GSHARE_VLEN      = 64;

   // The table is either usable or being swept back to its initial contents.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } gshare_state_e;

   // Everything the backend hands back about a resolved conditional branch.
   typedef struct packed {
      logic                        valid;
      logic [GSHARE_VLEN-1:0]      pc;
      logic                        taken;
      logic                        mispredict;
      logic [GSHARE_HIST_BITS-1:0] ghr;
   } gshare_update_t;

endpackage

// File: rtl/gshare_bht_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter_next
// Pure combinational next value of a CTR_BITS-wide saturating counter.
// Reused by the gshare table and intended for future tournament/TAGE blocks.
//   ctr      - current counter value
//   taken    - resolved direction: 1 counts up, 0 counts down
//   ctr_next - updated counter, clamped to [0, 2^CTR_BITS-1]
// ---------------------------------------------------------------------------
module sat_counter_next #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr,
   input  logic                taken,
   output logic [CTR_BITS-1:0] ctr_next
);

   // Step towards the resolved direction, holding at either end of the range
   // so a long run of one outcome cannot wrap the counter around.
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != {CTR_BITS{1'b1}}) begin
            ctr_next = ctr + 1'b1;
         end
      end else begin
         if (ctr != {CTR_BITS{1'b0}}) begin
            ctr_next = ctr - 1'b1;
         end
      end
   end

endmodule

// File: rtl/gshare_bht.sv
// ---------------------------------------------------------------------------
// gshare_bht
// Gshare branch history table for the frontend. Rows are selected by the
// fetch PC row bits XORed with a speculatively updated global history
// register; each row holds one {valid, counter} entry per fetch slot.
//   clk_i, rst_i         - clock, synchronous active-high reset
//   flush_i              - wipe the table (row sweep) and clear the history
//   debug_mode_i         - blocks table writes, history recovery still runs
//   vpc_i                - fetch PC, predictions are combinational from it
//   spec_valid_i/taken_i - predicted branch leaving fetch, shifts history
//   ghr_o                - current history, travels with the branch
//   update_*             - resolved branch: trains the table, and on a
//                          mispredict rebuilds the history from its snapshot
//   prediction_valid_o   - per-slot entry valid
//   prediction_taken_o   - per-slot counter MSB
//   init_busy_o          - clear sweep in progress
// ---------------------------------------------------------------------------
module gshare_bht #(
   parameter int unsigned NR_ENTRIES      = 1024,
   parameter int unsigned INSTR_PER_FETCH = gshare_bht_pkg::INSTR_PER_FETCH,
   parameter int unsigned CTR_BITS        = gshare_bht_pkg::GSHARE_CTR_BITS,
   parameter int unsigned HIST_BITS       = gshare_bht_pkg::GSHARE_HIST_BITS,
   parameter int unsigned VLEN            = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       spec_valid_i,
   input  logic                       spec_taken_i,
   output logic [HIST_BITS-1:0]       ghr_o,
   input  logic                       update_valid_i,
   input  logic [VLEN-1:0]            update_pc_i,
   input  logic                       update_taken_i,
   input  logic                       update_mispredict_i,
   input  logic [HIST_BITS-1:0]       update_ghr_i,
   output logic [INSTR_PER_FETCH-1:0] prediction_valid_o,
   output logic [INSTR_PER_FETCH-1:0] prediction_taken_o,
   output logic                       init_busy_o
);

   import gshare_bht_pkg::*;

   localparam int unsigned NR_ROWS    = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_BITS   = $clog2(NR_ROWS);
   localparam int unsigned IPF_BITS   = $clog2(INSTR_PER_FETCH);
   localparam int unsigned SLOT_BITS  = (IPF_BITS > 0) ? IPF_BITS : 1;
   localparam int unsigned ENTRY_BITS = CTR_BITS + 1;
   localparam int unsigned ROW_LSB    = IPF_BITS + 1;
   localparam int unsigned ROW_MSB    = ROW_BITS + IPF_BITS;

   localparam logic [ENTRY_BITS-1:0] CLEAR_ENTRY = {1'b0, 1'b1, {(CTR_BITS-1){1'b0}}};
   localparam logic [ROW_BITS-1:0]   LAST_ROW    = ROW_BITS'(NR_ROWS - 1);

   gshare_state_e r_state;
   gshare_state_e w_stateNext;
   logic [ROW_BITS-1:0] r_clrPtr;
   logic [ROW_BITS-1:0] w_clrPtrNext;
   logic [HIST_BITS-1:0] r_ghr;

   logic [ENTRY_BITS-1:0] r_table [NR_ROWS][INSTR_PER_FETCH];

   logic [ROW_BITS-1:0]  w_readRow;
   logic [ROW_BITS-1:0]  w_wrRow;
   logic [SLOT_BITS-1:0] w_wrSlot;
   logic [CTR_BITS-1:0]  w_wrOldCtr;
   logic [CTR_BITS-1:0]  w_ctrNext;
   logic                 w_wrEn;
   logic                 w_unusedPcBits;

   // Row selection hashes the PC row bits with the (zero-extended) history,
   // so the same branch lands in different rows under different histories.
   assign w_readRow = vpc_i[ROW_MSB:ROW_LSB] ^ ROW_BITS'(r_ghr);
   assign w_wrRow   = update_pc_i[ROW_MSB:ROW_LSB] ^ ROW_BITS'(update_ghr_i);

   // The slot within a row comes from the instruction offset bits of the PC;
   // with a single prediction per fetch there is only slot 0.
   generate
      if (IPF_BITS > 0) begin : g_slot
         assign w_wrSlot = update_pc_i[IPF_BITS:1];
      end else begin : g_noSlot
         assign w_wrSlot = '0;
      end
   endgenerate

   // PC bits outside the row/slot fields do not take part in indexing.
   assign w_unusedPcBits = ^{vpc_i[VLEN-1:ROW_MSB+1], vpc_i[IPF_BITS:0],
                             update_pc_i[VLEN-1:ROW_MSB+1], update_pc_i[0]};

   // Training is only allowed once the sweep has finished and outside debug
   // mode; anything resolving during the sweep is simply lost.
   assign w_wrEn     = update_valid_i && !debug_mode_i && (r_state == IDLE);
   assign w_wrOldCtr = r_table[w_wrRow][w_wrSlot][CTR_BITS-1:0];

   sat_counter_next #(
      .CTR_BITS (CTR_BITS)
   ) u_satCounter (
      .ctr      (w_wrOldCtr),
      .taken    (update_taken_i),
      .ctr_next (w_ctrNext)
   );

   // Clear sweep state register. Reset always starts a fresh sweep from row 0
   // so the table never exposes whatever the array powered up with.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= CLEAR;
         r_clrPtr <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_clrPtr <= w_clrPtrNext;
      end
   end

   // Sweep sequencing: one row per cycle, leaving after the last row. A flush
   // at any point, even mid-sweep, restarts from row 0 so rows already visited
   // cannot keep stale training from before the flush.
   always_comb begin
      w_stateNext  = r_state;
      w_clrPtrNext = r_clrPtr;
      case (r_state)
         IDLE: begin
            if (flush_i) begin
               w_stateNext  = CLEAR;
               w_clrPtrNext = '0;
            end
         end
         CLEAR: begin
            if (flush_i) begin
               w_clrPtrNext = '0;
            end else if (r_clrPtr == LAST_ROW) begin
               w_stateNext  = IDLE;
               w_clrPtrNext = '0;
            end else begin
               w_clrPtrNext = r_clrPtr + 1'b1;
            end
         end
         default: begin
            w_stateNext  = CLEAR;
            w_clrPtrNext = '0;
         end
      endcase
   end

   // Counter storage. It deliberately has no reset: the sweep writes every
   // row to invalid/weakly-taken, and afterwards a resolved branch sets its
   // entry valid and steps the counter. A write lands at the clock edge, so a
   // same-cycle read of that row still sees the old entry.
   always_ff @(posedge clk_i) begin
      if (r_state == CLEAR) begin
         for (int s = 0; s < INSTR_PER_FETCH; s++) begin
            r_table[r_clrPtr][s] <= CLEAR_ENTRY;
         end
      end else if (w_wrEn) begin
         r_table[w_wrRow][w_wrSlot] <= {1'b1, w_ctrNext};
      end
   end

   // Global history. A mispredict rebuilds the history from the snapshot the
   // branch carried plus its real outcome, and that beats any speculative
   // shift in the same cycle because the younger speculative branch is on the
   // wrong path. Recovery ignores debug mode so fetch stays coherent.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_ghr <= '0;
      end else if (update_valid_i && update_mispredict_i) begin
         r_ghr <= {update_ghr_i[HIST_BITS-2:0], update_taken_i};
      end else if (spec_valid_i) begin
         r_ghr <= {r_ghr[HIST_BITS-2:0], spec_taken_i};
      end
   end

   // Predictions come straight out of the addressed row; while sweeping they
   // are held at zero so fetch never acts on a half-cleared table.
   always_comb begin
      prediction_valid_o = '0;
      prediction_taken_o = '0;
      if (r_state == IDLE) begin
         for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            prediction_valid_o[i] = r_table[w_readRow][i][CTR_BITS];
            prediction_taken_o[i] = r_table[w_readRow][i][CTR_BITS-1];
         end
      end
   end

   assign ghr_o       = r_ghr;
   assign init_busy_o = (r_state == CLEAR);

endmodule

// File: tb/tb_gshare_bht.sv
// ---------------------------------------------------------------------------
// tb_gshare_bht
// Self-checking bench for gshare_bht (512 entries, 2 slots -> 256 rows,
// 8-bit history). A behavioural model tracks table contents, history and
// sweep progress; a compare process checks every output on every negedge,
// and a directed sequence pins the model with hand-computed values before a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_gshare_bht;

   localparam int NR_ENTRIES = 512;
   localparam int IPF        = 2;
   localparam int NR_ROWS    = NR_ENTRIES / IPF;
   localparam int HIST       = 8;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        debug;
   logic [63:0] vpc;
   logic        specValid;
   logic        specTaken;
   logic [7:0]  ghrOut;
   logic        updValid;
   logic [63:0] updPc;
   logic        updTaken;
   logic        updMis;
   logic [7:0]  updGhr;
   logic [1:0]  predValid;
   logic [1:0]  predTaken;
   logic        busy;

   int testsRun;
   int testsFailed;

   int mCtr   [NR_ROWS][IPF];
   bit mValid [NR_ROWS][IPF];
   int mBusyLeft;
   int mGhr;

   gshare_bht #(
      .NR_ENTRIES      (NR_ENTRIES),
      .INSTR_PER_FETCH (IPF),
      .CTR_BITS        (2),
      .HIST_BITS       (HIST),
      .VLEN            (64)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .flush_i             (flush),
      .debug_mode_i        (debug),
      .vpc_i               (vpc),
      .spec_valid_i        (specValid),
      .spec_taken_i        (specTaken),
      .ghr_o               (ghrOut),
      .update_valid_i      (updValid),
      .update_pc_i         (updPc),
      .update_taken_i      (updTaken),
      .update_mispredict_i (updMis),
      .update_ghr_i        (updGhr),
      .prediction_valid_o  (predValid),
      .prediction_taken_o  (predTaken),
      .init_busy_o         (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report it when the values differ.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and land just after the edge, away from sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of speculative/update traffic, then return to quiet.
   task automatic applyStimulus(input logic sv, input logic st, input logic uv,
                                input logic [63:0] upc, input logic ut,
                                input logic um, input logic [7:0] ughr);
      specValid = sv;
      specTaken = st;
      updValid  = uv;
      updPc     = upc;
      updTaken  = ut;
      updMis    = um;
      updGhr    = ughr;
      tick();
      specValid = 1'b0;
      specTaken = 1'b0;
      updValid  = 1'b0;
      updPc     = '0;
      updTaken  = 1'b0;
      updMis    = 1'b0;
      updGhr    = '0;
   endtask

   // Point the fetch PC somewhere and let the combinational read settle.
   task automatic peek(input logic [63:0] pc);
      vpc = pc;
      #1;
   endtask

   task automatic modelClear();
      for (int r = 0; r < NR_ROWS; r++) begin
         for (int s = 0; s < IPF; s++) begin
            mValid[r][s] = 1'b0;
            mCtr[r][s]   = 2;
         end
      end
   endtask

   // Reference model, stepped on each rising edge from the inputs in force.
   // A sweep is modelled as "table wiped now, unusable for NR_ROWS cycles":
   // outputs are blanked and training dropped for the whole sweep anyway.
   initial begin
      int r;
      int s;
      modelClear();
      mBusyLeft = NR_ROWS;
      mGhr      = 0;
      forever begin
         @(posedge clk);
         if (updValid && !debug && mBusyLeft == 0) begin
            r = int'((updPc >> 2) % NR_ROWS) ^ int'(updGhr);
            s = int'((updPc >> 1) % IPF);
            mValid[r][s] = 1'b1;
            if (updTaken) mCtr[r][s] = (mCtr[r][s] < 3) ? mCtr[r][s] + 1 : 3;
            else          mCtr[r][s] = (mCtr[r][s] > 0) ? mCtr[r][s] - 1 : 0;
         end
         if (rst || flush) begin
            modelClear();
            mBusyLeft = NR_ROWS;
         end else if (mBusyLeft > 0) begin
            mBusyLeft--;
         end
         if (rst || flush)                mGhr = 0;
         else if (updValid && updMis)     mGhr = ((int'(updGhr) << 1) | int'(updTaken)) % 256;
         else if (specValid)              mGhr = ((mGhr << 1) | int'(specTaken)) % 256;
      end
   end

   // Compare process: every negedge after the first reset edge, all outputs
   // against the model.
   initial begin
      logic [1:0] expV;
      logic [1:0] expT;
      int row;
      @(posedge clk);
      forever begin
         @(negedge clk);
         row = int'((vpc >> 2) % NR_ROWS) ^ mGhr;
         for (int i = 0; i < IPF; i++) begin
            expV[i] = (mBusyLeft == 0) && mValid[row][i];
            expT[i] = (mBusyLeft == 0) && (mCtr[row][i] >= 2);
         end
         checkOutput("cyc_ghr",   64'(ghrOut),    64'(mGhr));
         checkOutput("cyc_busy",  64'(busy),      64'(mBusyLeft > 0));
         checkOutput("cyc_valid", 64'(predValid), 64'(expV));
         checkOutput("cyc_taken", 64'(predTaken), 64'(expT));
      end
   end

   // Directed sequence from the test plan, then randomized traffic.
   initial begin
      int n;
      logic [1:0] satT [7];
      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b1; flush = 1'b0; debug = 1'b0; vpc = '0;
      specValid = 1'b0; specTaken = 1'b0;
      updValid = 1'b0; updPc = '0; updTaken = 1'b0; updMis = 1'b0; updGhr = '0;

      // Reset: busy, blanked predictions, clear history.
      tick(); tick(); tick();
      checkOutput("rst_busy",  64'(busy),      64'd1);
      checkOutput("rst_valid", 64'(predValid), 64'd0);
      checkOutput("rst_taken", 64'(predTaken), 64'd0);
      checkOutput("rst_ghr",   64'(ghrOut),    64'd0);
      rst = 1'b0;
      n = 0;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      checkOutput("rst_sweep_len", 64'(n), 64'd256);

      // Every row after the sweep: invalid, weakly taken.
      for (int r = 0; r < NR_ROWS; r++) begin
         peek(64'(r) << 2);
         checkOutput("swept_valid", 64'(predValid), 64'd0);
         checkOutput("swept_taken", 64'(predTaken), 64'h3);
         tick();
      end

      // Saturation at 0x80000010 (row 4 slot 0): 3 taken then 4 not taken.
      satT = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0010, (k < 3), 1'b0, 8'h00);
         peek(64'h8000_0010);
         checkOutput("sat_taken", 64'(predTaken), 64'(satT[k]));
         checkOutput("sat_valid", 64'(predValid), 64'h1);
      end

      // Flush, then flush again on the third sweep cycle; sweep updates lost.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      peek(64'h8000_0010);
      checkOutput("flush_busy",  64'(busy),      64'd1);
      checkOutput("flush_valid", 64'(predValid), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 8'h00);
      flush = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 8'h00);
      flush = 1'b0;
      n = 0;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      checkOutput("flush_restart_len", 64'(n), 64'd256);
      peek(64'h8000_0010);
      checkOutput("flush_after_valid", 64'(predValid), 64'd0);
      checkOutput("flush_after_taken", 64'(predTaken), 64'h3);

      // Aliasing through history: trained with ghr 0x01 lands in row 5.
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h10, 1'b1, 1'b0, 8'h01);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h10, 1'b1, 1'b0, 8'h01);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
      peek(64'h10);
      checkOutput("alias_ghr",   64'(ghrOut),    64'h01);
      checkOutput("alias_valid", 64'(predValid), 64'h1);
      checkOutput("alias_taken", 64'(predTaken), 64'h3);

      // Debug-mode mispredict: history recovers to 0, table untouched.
      debug = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b1, 8'h00);
      debug = 1'b0;
      peek(64'h10);
      checkOutput("alias_ghr0",      64'(ghrOut),    64'h00);
      checkOutput("alias_row4_valid", 64'(predValid), 64'h0);
      peek(64'h14);
      checkOutput("alias_row5_taken", 64'(predTaken), 64'h3);

      // Recovery beats a simultaneous speculative shift.
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 8'h00);
      checkOutput("prio_ghr_pre", 64'(ghrOut), 64'h0F);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'h30, 1'b0, 1'b1, 8'h80);
      checkOutput("prio_ghr_post", 64'(ghrOut), 64'h00);

      // Debug mode at PC 0x20: recovery to 0x07, row 0x0B stays invalid.
      debug = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h20, 1'b1, 1'b1, 8'h03);
      debug = 1'b0;
      peek(64'h30);
      checkOutput("debug_ghr",   64'(ghrOut),    64'h07);
      checkOutput("debug_valid", 64'(predValid), 64'h0);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 1999) == 0);
         flush     = ($urandom_range(0, 799) == 0);
         debug     = ($urandom_range(0, 9) == 0);
         vpc       = {32'($urandom), 22'($urandom), 10'($urandom)};
         specValid = 1'($urandom);
         specTaken = 1'($urandom);
         updValid  = 1'($urandom);
         updPc     = {32'($urandom), 22'($urandom), 10'($urandom)};
         updTaken  = ($urandom_range(0, 3) != 0);
         updMis    = ($urandom_range(0, 5) == 0);
         updGhr    = 8'($urandom);
         tick();
      end

      rst = 1'b0; flush = 1'b0; debug = 1'b0;
      specValid = 1'b0; updValid = 1'b0; updMis = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
